// File: rtl/mlp_layer_sequencer.sv
// Sequencer for the 3-layer MLP datapath: walks the layers, neurons and input
// indices and drives the memory address, MAC strobes and result writes.
module mlp_layer_sequencer #(
  parameter int IN_N = 4,
  parameter int L0_N = 4,
  parameter int L1_N = 4,
  parameter int L2_N = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        out_ready,
  output logic [15:0] mem_addr,
  output logic        mac_clear,
  output logic        mac_en,
  output logic [9:0]  mac_k,
  output logic        bias_en,
  output logic        out_wr,
  output logic [1:0]  out_layer,
  output logic [3:0]  out_neuron,
  output logic        relu_en,
  output logic        busy,
  output logic        done
);

  localparam logic [9:0] F0 = 10'(IN_N - 1);
  localparam logic [9:0] F1 = 10'(L0_N - 1);
  localparam logic [9:0] F2 = 10'(L1_N - 1);
  localparam logic [3:0] C0 = 4'(L0_N - 1);
  localparam logic [3:0] C1 = 4'(L1_N - 1);
  localparam logic [3:0] C2 = 4'(L2_N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    BIAS,
    BWAIT,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  layer;
  logic [3:0]  neuron;
  logic [9:0]  k;
  logic [9:0]  fan_last;
  logic [3:0]  cnt_last;
  logic [5:0]  slot;

  assign slot = {layer, neuron};

  always_comb begin
    fan_last = F0;
    cnt_last = C0;
    case (layer)
      2'd1: begin
        fan_last = F1;
        cnt_last = C1;
      end
      2'd2: begin
        fan_last = F2;
        cnt_last = C2;
      end
      default: ;
    endcase
  end

  // Outputs are set on the transition into the state they belong to,
  // so every strobe is a plain register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      layer      <= '0;
      neuron     <= '0;
      k          <= '0;
      mem_addr   <= '0;
      mac_clear  <= 1'b0;
      mac_en     <= 1'b0;
      mac_k      <= '0;
      bias_en    <= 1'b0;
      out_wr     <= 1'b0;
      out_layer  <= '0;
      out_neuron <= '0;
      relu_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mac_clear <= 1'b0;
      mac_en    <= 1'b0;
      bias_en   <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            layer     <= '0;
            neuron    <= '0;
            k         <= '0;
            mem_addr  <= '0;
            mac_clear <= 1'b1;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          k        <= '0;
          mem_addr <= {slot, 10'd0};
          state    <= ISSUE;
        end
        ISSUE: begin
          // Data for this address returns next cycle.
          mac_en <= 1'b1;
          mac_k  <= k;
          if (k == fan_last) begin
            mem_addr <= {slot, 10'd0};
            state    <= BIAS;
          end else begin
            k        <= k + 10'd1;
            mem_addr <= {slot, k + 10'd1};
          end
        end
        BIAS: begin
          bias_en <= 1'b1;
          state   <= BWAIT;
        end
        BWAIT: begin
          out_wr     <= 1'b1;
          out_layer  <= layer;
          out_neuron <= neuron;
          relu_en    <= (layer != 2'd2);
          state      <= WRITE;
        end
        WRITE: begin
          if (out_ready) begin
            out_wr <= 1'b0;
            if (neuron != cnt_last) begin
              neuron    <= neuron + 4'd1;
              mem_addr  <= {layer, neuron + 4'd1, 10'd0};
              mac_clear <= 1'b1;
              state     <= CLEAR;
            end else if (layer != 2'd2) begin
              layer     <= layer + 2'd1;
              neuron    <= '0;
              mem_addr  <= {layer + 2'd1, 4'd0, 10'd0};
              mac_clear <= 1'b1;
              state     <= CLEAR;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: walks the layer/neuron/k schedule with nested
// loops and compares every cycle, with random backpressure and start noise.
module tb_mlp_layer_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;

  logic [15:0] addr_a, addr_b, addr;
  logic [9:0]  mk_a, mk_b, mk;
  logic [1:0]  ol_a, ol_b, ol;
  logic [3:0]  on_a, on_b, on;
  logic clr_a, clr_b, clr, en_a, en_b, en;
  logic bias_a, bias_b, bias, wr_a, wr_b, wr;
  logic relu_a, relu_b, relu, busy_a, busy_b, busy;
  logic done_a, done_b, done;

  int checks = 0;
  int errors = 0;
  int ndone_a = 0;
  int ndone_b = 0;

  always #5 clk = ~clk;

  mlp_layer_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel),
    .out_ready(out_ready), .mem_addr(addr_a),
    .mac_clear(clr_a), .mac_en(en_a), .mac_k(mk_a),
    .bias_en(bias_a), .out_wr(wr_a), .out_layer(ol_a),
    .out_neuron(on_a), .relu_en(relu_a), .busy(busy_a),
    .done(done_a)
  );

  mlp_layer_sequencer #(
    .IN_N(1), .L0_N(1), .L1_N(16), .L2_N(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start & sel),
    .out_ready(out_ready), .mem_addr(addr_b),
    .mac_clear(clr_b), .mac_en(en_b), .mac_k(mk_b),
    .bias_en(bias_b), .out_wr(wr_b), .out_layer(ol_b),
    .out_neuron(on_b), .relu_en(relu_b), .busy(busy_b),
    .done(done_b)
  );

  assign addr = sel ? addr_b : addr_a;
  assign mk   = sel ? mk_b : mk_a;
  assign ol   = sel ? ol_b : ol_a;
  assign on   = sel ? on_b : on_a;
  assign clr  = sel ? clr_b : clr_a;
  assign en   = sel ? en_b : en_a;
  assign bias = sel ? bias_b : bias_a;
  assign wr   = sel ? wr_b : wr_a;
  assign relu = sel ? relu_b : relu_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;

  always @(negedge clk) begin
    if (done_a) ndone_a++;
    if (done_b) ndone_b++;
  end

  task automatic chk(input string tag, input logic [39:0] obs,
                     input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // strobes = {clear, mac_en, bias_en, out_wr, done, busy}
  task automatic chk_cycle(input string tag, input logic [5:0] s,
                           input bit aval, input logic [15:0] a,
                           input logic [9:0] k);
    chk({tag, ".strobes"}, 40'({clr, en, bias, wr, done, busy}), 40'(s));
    if (aval) chk({tag, ".addr"}, 40'(addr), 40'(a));
    if (s[4]) chk({tag, ".mac_k"}, 40'(mk), 40'(k));
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 40'({addr, clr, en, mk, bias, wr, ol, on, relu, busy, done}),
        40'd0);
  endtask

  // One inference from IDLE. stall0 forces that many not-ready cycles at the
  // first WRITE; abort resets the DUT in the 3rd ISSUE cycle of layer 1.
  task automatic run(input int fan0, input int fan1, input int fan2,
                     input int c0, input int c1, input int c2,
                     input int stall0, input bit abort);
    int fan [3];
    int cnt [3];
    int stall;
    bit r;
    fan = '{fan0, fan1, fan2};
    cnt = '{c0, c1, c2};
    stall = stall0;
    start = 1'b1;
    tick();
    for (int l = 0; l < 3; l++) begin
      for (int n = 0; n < cnt[l]; n++) begin
        logic [5:0] s;
        s = 6'(l * 16 + n);
        chk_cycle("clear", 6'b100001, 1'b1, {s, 10'd0}, 10'd0);
        start = 1'($urandom);
        out_ready = 1'($urandom);
        tick();
        for (int k = 0; k < fan[l]; k++) begin
          chk_cycle("issue", (k > 0) ? 6'b010001 : 6'b000001, 1'b1,
                    {s, 10'(k)}, 10'(k - 1));
          if (abort && l == 1 && n == 0 && k == 2) begin
            reset = 1'b1;
            start = 1'b0;
            tick();
            chk_zero("abort_zero");
            reset = 1'b0;
            tick();
            chk_zero("abort_idle");
            return;
          end
          start = 1'($urandom);
          out_ready = 1'($urandom);
          tick();
        end
        chk_cycle("bias", 6'b010001, 1'b1, {s, 10'd0}, 10'(fan[l] - 1));
        start = 1'($urandom);
        tick();
        chk_cycle("bwait", 6'b001001, 1'b0, 16'd0, 10'd0);
        start = 1'($urandom);
        tick();
        do begin
          if (stall > 0) begin
            r = 1'b0;
            stall--;
          end else begin
            r = ($urandom_range(3) != 0);
          end
          chk_cycle("write", 6'b000101, 1'b0, 16'd0, 10'd0);
          chk("write.id", 40'({ol, on, relu}),
              40'({2'(l), 4'(n), l != 2}));
          out_ready = r;
          start = 1'($urandom);
          tick();
        end while (!r);
      end
    end
    chk_cycle("done", 6'b000011, 1'b0, 16'd0, 10'd0);
    start = 1'b0;
    tick();
    chk_cycle("idle", 6'b000000, 1'b0, 16'd0, 10'd0);
    tick();
    chk_cycle("idle2", 6'b000000, 1'b0, 16'd0, 10'd0);
  endtask

  initial begin
    tick();
    tick();
    sel = 1'b0;
    chk_zero("reset_a");
    sel = 1'b1;
    chk_zero("reset_b");
    reset = 1'b0;
    sel = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_zero("idle_a");

    run(4, 4, 4, 4, 4, 1, 0, 1'b0);
    run(4, 4, 4, 4, 4, 1, 5, 1'b0);
    run(4, 4, 4, 4, 4, 1, 0, 1'b1);
    run(4, 4, 4, 4, 4, 1, 0, 1'b0);

    sel = 1'b1;
    tick();
    run(1, 1, 16, 1, 16, 1, 0, 1'b0);

    for (int i = 0; i < 4; i++) tick();
    chk("done_count_a", 40'(ndone_a), 40'd3);
    chk("done_count_b", 40'(ndone_b), 40'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Top-level controller for the 3-layer MLP datapath.
- Walks every layer, neuron and input index, and drives the shared 16-bit address into the weight memory and bias memory.
- Bias memory decodes addr[15:10] as neuron slot = layer*16 + neuron; weight memory uses the full address, with addr[9:0] as input index.
- Emits MAC clear/enable, bias-add and result-write strobes aligned to the 1-cycle registered read latency of both memories.

Parameters:
- IN_N, 4, fan-in of layer 0 (network inputs); range 1..1023.
- L0_N, 4, neuron count of layer 0; range 1..16.
- L1_N, 4, neuron count of layer 1; range 1..16.
- L2_N, 1, neuron count of layer 2 (output layer); range 1..16.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin one inference; sampled only in IDLE.
- out_ready  in  1  result sink accepts out_wr this cycle.
- mem_addr  out  16  {slot[5:0], k[9:0]} to weight memory and bias memory.
- mac_clear  out  1  zero the accumulator.
- mac_en  out  1  weight/activation data valid this cycle; accumulate.
- mac_k  out  10  input index belonging to the current mac_en.
- bias_en  out  1  bias memory output valid this cycle; add to accumulator.
- out_wr  out  1  neuron result valid; held until out_ready.
- out_layer  out  2  layer of the current result.
- out_neuron  out  4  neuron of the current result.
- relu_en  out  1  apply activation; 1 for layers 0..1, 0 for the last layer; valid with out_wr.
- busy  out  1  high from the first CLEAR through DONE.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset: state=IDLE; all outputs 0, including mem_addr, mac_k, out_layer and out_neuron; layer, neuron and k counters 0. Reset in any state aborts immediately; no further strobes are issued.
- Fan-in per layer: layer0=IN_N, layer1=L0_N, layer2=L1_N. Neuron count per layer: L0_N, L1_N, L2_N. slot = layer*16 + neuron (6 bits).
- IDLE: busy=0. start=1 -> layer=0, neuron=0, go CLEAR. start in any other state is ignored.
- CLEAR (1 cycle): mac_clear=1; mem_addr={slot,10'd0}; k=0; -> ISSUE.
- ISSUE (fan_in cycles):
  - mem_addr={slot,k}.
  - Registered issue flag: mac_en=1 and mac_k=k on the following cycle (1-cycle memory latency).
  - k increments each cycle; when k==fan_in-1 -> BIAS.
- BIAS (1 cycle):
  - mem_addr={slot,10'd0}, so the bias memory reads the slot.
  - mac_en for the last weight (k=fan_in-1) occurs this cycle.
  - -> BWAIT.
- BWAIT (1 cycle): bias_en=1, since bias data arrives here; -> WRITE.
- WRITE:
  - out_wr=1; out_layer, out_neuron and relu_en stable; mem_addr holds.
  - Held while out_ready=0.
  - On out_wr&&out_ready:
    - neuron < count-1: neuron++, -> CLEAR.
    - Else if layer < 2: layer++, neuron=0, -> CLEAR.
    - Else -> DONE.
- DONE (1 cycle): done=1, busy=1; -> IDLE, busy=0 next cycle.
- Strobe exclusivity: mac_clear, mac_en, bias_en and out_wr are never high in the same cycle.
- Latency per neuron = fan_in + 4 cycles with out_ready tied high. Defaults: 4*8 + 4*8 + 1*8 = 72 cycles from first CLEAR to last WRITE; done on the 73rd cycle.
- Wrap-around:
  - k never exceeds fan_in-1.
  - neuron never exceeds count-1.
  - slot never exceeds 32+L2_N-1.
- out_ready asserted outside WRITE has no effect.

Test Plan:
- Defaults, out_ready=1, pulse start:
  - first mem_addr=0x0000 with mac_clear.
  - ISSUE addresses 0x0000..0x0003.
  - mac_en on the 4 following cycles, mac_k 0..3.
  - bias_en 2 cycles after the last issue.
  - out_wr (layer0, neuron0) with relu_en=1.
  - done 73 cycles after the first CLEAR.
- Slot coverage, defaults: out_wr sequence is (0,0..3), (1,0..3), (2,0). Bias reads occur at slots 0-3, 16-19, 32; final out_wr has relu_en=0.
- Backpressure: hold out_ready=0 for 5 cycles at the first WRITE -> out_wr held 6 cycles with out_layer and out_neuron stable; next CLEAR occurs only after acceptance.
- Reset at the 3rd ISSUE cycle of layer1 -> all outputs 0 the next cycle; a subsequent start restarts at slot 0.
- start pulses while busy -> ignored; exactly one done per accepted start.
- IN_N=1, L0_N=1, L1_N=16, L2_N=1 -> layer2 issues k 0..15 at slot 32; 1 + 16 + 1 out_wr total.
